// File: rtl/sdr_arb_pkg.sv
// Shared types and default sizes for the SDRAM bulk-transfer arbiter.
package sdr_arb_pkg;

    localparam int DATA_W_DEF      = 2048;
    localparam int ADDR_W_DEF      = 32;
    localparam int NELEM_W_DEF     = 30;
    localparam int MAX_NELEMS_DEF  = DATA_W_DEF / 32;
    localparam int TIMEOUT_CYC_DEF = 65536;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        CL_READ  = 1'b0,
        CL_WRITE = 1'b1
    } client_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-client round-robin picker: on a tie the client not served last wins.
module rr_arb2
    import sdr_arb_pkg::*;
(
    input  logic    i_rd_req,
    input  logic    i_wr_req,
    input  client_t i_last_served,
    output client_t o_choice,
    output logic    o_valid
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        o_valid  = i_rd_req | i_wr_req;
        o_choice = CL_READ;
        if (i_rd_req && i_wr_req) begin
            o_choice = (i_last_served == CL_READ) ? CL_WRITE : CL_READ;
        end else if (i_wr_req) begin
            o_choice = CL_WRITE;
        end
    end

endmodule

// File: rtl/sdr_xfer_arbiter.sv
// Shares the SDR bulk-transfer port between a read and a write client, one transfer at a time.
// Define SDR_TIMEOUT_EN to build a watchdog that aborts a transfer after TIMEOUT_CYC cycles.
module sdr_xfer_arbiter
    import sdr_arb_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int NELEM_W     = NELEM_W_DEF,
    parameter int MAX_NELEMS  = MAX_NELEMS_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic               sdr_clk,
    input  logic               sdr_reset,
    input  logic               rd_req,
    input  logic [ADDR_W-1:0]  rd_addr,
    input  logic [NELEM_W-1:0] rd_nelems,
    output logic               rd_gnt,
    output logic               rd_done,
    output logic [DATA_W-1:0]  rd_data,
    input  logic               wr_req,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [NELEM_W-1:0] wr_nelems,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               wr_gnt,
    output logic               wr_done,
    output logic               err,
    output logic               busy,
    output logic               sdr_readstart,
    output logic               sdr_writestart,
    output logic [ADDR_W-1:0]  sdr_baseaddr,
    output logic [NELEM_W-1:0] sdr_nelems,
    output logic [DATA_W-1:0]  sdr_writedata,
    input  logic [DATA_W-1:0]  sdr_readdata,
    input  logic               sdr_readend,
    input  logic               sdr_writeend
);

    state_t               r_state;
    client_t              r_sel;
    client_t              r_last;
    logic                 r_err;
    logic [ADDR_W-1:0]    r_baseaddr;
    logic [NELEM_W-1:0]   r_nelems;
    logic [DATA_W-1:0]    r_writedata;
    logic [DATA_W-1:0]    r_rd_data;

    client_t              w_pick;
    logic                 w_pick_valid;
    logic [NELEM_W-1:0]   w_nelems_sel;
    logic                 w_count_ok;
    logic                 w_end_match;
    logic                 w_timeout;

    rr_arb2 u_rr_arb2 (
        .i_rd_req      (rd_req),
        .i_wr_req      (wr_req),
        .i_last_served (r_last),
        .o_choice      (w_pick),
        .o_valid       (w_pick_valid)
    );

    assign w_nelems_sel = (w_pick == CL_READ) ? rd_nelems : wr_nelems;
    assign w_count_ok   = (w_nelems_sel != '0) && (w_nelems_sel <= NELEM_W'(MAX_NELEMS));
    assign w_end_match  = (r_sel == CL_READ) ? sdr_readend : sdr_writeend;

`ifdef SDR_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] r_cnt;

    // r_cnt is 0 in the first WAIT cycle, so TIMEOUT_CYC-2 is the last WAIT cycle before DONE.
    always_ff @(posedge sdr_clk) begin
        if (sdr_reset || r_state != WAIT) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_timeout = (r_state == WAIT) && (r_cnt == CNT_W'(TIMEOUT_CYC - 2));
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;

    assign w_timeout = 1'b0;
`endif

    // NOTE: state uses non-blocking assignments; the wide data registers are plain flops, so they reset too.
    always_ff @(posedge sdr_clk) begin
        if (sdr_reset) begin
            r_state     <= IDLE;
            r_sel       <= CL_READ;
            r_last      <= CL_WRITE;
            r_err       <= 1'b0;
            r_baseaddr  <= '0;
            r_nelems    <= '0;
            r_writedata <= '0;
            r_rd_data   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_valid) begin
                        r_sel      <= w_pick;
                        r_baseaddr <= (w_pick == CL_READ) ? rd_addr : wr_addr;
                        r_nelems   <= w_nelems_sel;
                        if (w_pick == CL_WRITE) begin
                            r_writedata <= wr_data;
                        end
                        r_err   <= !w_count_ok;
                        r_state <= w_count_ok ? ISSUE : DONE;
                    end
                end
                ISSUE, WAIT: begin
                    if (w_end_match) begin
                        if (r_sel == CL_READ) begin
                            r_rd_data <= sdr_readdata;
                        end
                        r_state <= DONE;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                DONE: begin
                    r_last     <= r_sel;
                    r_err      <= 1'b0;
                    r_baseaddr <= '0;
                    r_nelems   <= '0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy           = (r_state != IDLE);
    assign sdr_readstart  = (r_state == ISSUE) && (r_sel == CL_READ);
    assign sdr_writestart = (r_state == ISSUE) && (r_sel == CL_WRITE);
    assign rd_gnt         = sdr_readstart;
    assign wr_gnt         = sdr_writestart;
    assign rd_done        = (r_state == DONE) && (r_sel == CL_READ);
    assign wr_done        = (r_state == DONE) && (r_sel == CL_WRITE);
    assign err            = (r_state == DONE) && r_err;
    assign sdr_baseaddr   = r_baseaddr;
    assign sdr_nelems     = r_nelems;
    assign sdr_writedata  = r_writedata;
    assign rd_data        = r_rd_data;

endmodule

// File: tb/tb_sdr_xfer_arbiter.sv
// Scoreboard bench for sdr_xfer_arbiter: expected issues/completions are queued with the stimulus.
module tb_sdr_xfer_arbiter;
    import sdr_arb_pkg::*;

    localparam int DW   = 2048;
    localparam int AW   = 32;
    localparam int NW   = 30;
    localparam int MAXN = 64;
    localparam int TMO  = 16;

    logic           sdr_clk   = 1'b0;
    logic           sdr_reset = 1'b1;
    logic           rd_req    = 1'b0;
    logic [AW-1:0]  rd_addr   = '0;
    logic [NW-1:0]  rd_nelems = '0;
    logic           wr_req    = 1'b0;
    logic [AW-1:0]  wr_addr   = '0;
    logic [NW-1:0]  wr_nelems = '0;
    logic [DW-1:0]  wr_data   = '0;
    logic [DW-1:0]  sdr_readdata = '0;
    logic           sdr_readend  = 1'b0;
    logic           sdr_writeend = 1'b0;

    logic           rd_gnt, rd_done, wr_gnt, wr_done, err, busy;
    logic           sdr_readstart, sdr_writestart;
    logic [DW-1:0]  rd_data, sdr_writedata;
    logic [AW-1:0]  sdr_baseaddr;
    logic [NW-1:0]  sdr_nelems;

    sdr_xfer_arbiter #(
        .DATA_W(DW), .ADDR_W(AW), .NELEM_W(NW), .MAX_NELEMS(MAXN), .TIMEOUT_CYC(TMO)
    ) dut (
        .sdr_clk(sdr_clk), .sdr_reset(sdr_reset),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_nelems(rd_nelems),
        .rd_gnt(rd_gnt), .rd_done(rd_done), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_nelems(wr_nelems), .wr_data(wr_data),
        .wr_gnt(wr_gnt), .wr_done(wr_done), .err(err), .busy(busy),
        .sdr_readstart(sdr_readstart), .sdr_writestart(sdr_writestart),
        .sdr_baseaddr(sdr_baseaddr), .sdr_nelems(sdr_nelems), .sdr_writedata(sdr_writedata),
        .sdr_readdata(sdr_readdata), .sdr_readend(sdr_readend), .sdr_writeend(sdr_writeend)
    );

    always #5 sdr_clk = ~sdr_clk;

    typedef struct {
        client_t       dir;
        logic [AW-1:0] addr;
        logic [NW-1:0] n;
        logic [DW-1:0] wdata;
    } iss_t;

    typedef struct {
        client_t       dir;
        logic          err;
        logic [DW-1:0] rdata;
    } done_t;

    iss_t          iss_q[$];
    done_t         done_q[$];
    int            checks    = 0;
    int            failures  = 0;
    int            cyc       = 0;
    int            start_cnt = 0;
    int            done_cnt  = 0;
    int            start_cyc = 0;
    int            done_cyc  = 0;
    int            req_cyc   = 0;
    int            end_cyc   = 0;
    int            n_st      = 0;
    int            n_dn      = 0;
    logic [DW-1:0] model_rd_data = '0;

    always @(posedge sdr_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] fold(input logic [DW-1:0] v);
        logic [63:0] a;
        a = '0;
        for (int i = 0; i < DW / 64; i++) a = {a[62:0], a[63]} ^ v[i*64 +: 64];
        return a;
    endfunction

    function automatic logic [DW-1:0] fill(input logic [31:0] w);
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = w;
        return v;
    endfunction

    always @(negedge sdr_clk) begin : mon
        iss_t  ie;
        done_t de;
        if (!sdr_reset) begin
            if (sdr_readstart || sdr_writestart) begin
                start_cnt++;
                start_cyc = cyc;
                check("start_expected", 64'(iss_q.size() != 0), 64'd1);
                if (iss_q.size() != 0) begin
                    ie = iss_q.pop_front();
                    check("readstart", 64'(sdr_readstart), 64'(ie.dir == CL_READ));
                    check("writestart", 64'(sdr_writestart), 64'(ie.dir == CL_WRITE));
                    check("rd_gnt", 64'(rd_gnt), 64'(ie.dir == CL_READ));
                    check("wr_gnt", 64'(wr_gnt), 64'(ie.dir == CL_WRITE));
                    check("start_addr", 64'(sdr_baseaddr), 64'(ie.addr));
                    check("start_nelems", 64'(sdr_nelems), 64'(ie.n));
                    if (ie.dir == CL_WRITE) check("start_wdata", fold(sdr_writedata), fold(ie.wdata));
                end
            end
            if (rd_done || wr_done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_expected", 64'(done_q.size() != 0), 64'd1);
                if (done_q.size() != 0) begin
                    de = done_q.pop_front();
                    check("rd_done", 64'(rd_done), 64'(de.dir == CL_READ));
                    check("wr_done", 64'(wr_done), 64'(de.dir == CL_WRITE));
                    check("done_err", 64'(err), 64'(de.err));
                    if (de.dir == CL_READ) check("rd_data", fold(rd_data), fold(de.rdata));
                end
            end else begin
                check("err_idle", 64'(err), 64'd0);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge sdr_clk);
        #1;
    endtask

    task automatic push_iss(input client_t d, input logic [AW-1:0] a, input logic [NW-1:0] n,
                            input logic [DW-1:0] w);
        iss_q.push_back('{dir: d, addr: a, n: n, wdata: w});
        n_st++;
    endtask

    task automatic push_done(input client_t d, input logic e, input logic [DW-1:0] r);
        if (d == CL_READ && !e) model_rd_data = r;
        done_q.push_back('{dir: d, err: e, rdata: (d == CL_READ && e) ? model_rd_data : r});
        n_dn++;
    endtask

    task automatic wait_start(input string tag, input int target);
        int k = 0;
        while (start_cnt < target && k < 200) begin
            @(negedge sdr_clk);
            #1;
            k++;
        end
        check({tag, "_start_seen"}, 64'(start_cnt >= target), 64'd1);
    endtask

    task automatic wait_done(input string tag, input int target);
        int k = 0;
        while (done_cnt < target && k < 200) begin
            @(negedge sdr_clk);
            #1;
            k++;
        end
        check({tag, "_done_seen"}, 64'(done_cnt >= target), 64'd1);
    endtask

    task automatic pulse_end(input client_t d, input logic [DW-1:0] data);
        if (d == CL_READ) begin
            sdr_readend  = 1'b1;
            sdr_readdata = data;
        end else begin
            sdr_writeend = 1'b1;
        end
        end_cyc = cyc;
        tick();
        sdr_readend  = 1'b0;
        sdr_writeend = 1'b0;
        sdr_readdata = '0;
    endtask

    task automatic check_all_zero(input string tag);
        @(negedge sdr_clk);
        check({tag, "_pulses"}, 64'({busy, rd_gnt, wr_gnt, rd_done, wr_done, err,
                                     sdr_readstart, sdr_writestart}), 64'd0);
        check({tag, "_addr"}, 64'(sdr_baseaddr), 64'd0);
        check({tag, "_nelems"}, 64'(sdr_nelems), 64'd0);
        check({tag, "_rd_data"}, 64'(|rd_data), 64'd0);
        check({tag, "_wdata"}, 64'(|sdr_writedata), 64'd0);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        tick(3);
        check_all_zero("reset");
        tick();
        sdr_reset = 1'b0;
        tick();

        // contention straight out of reset: read wins the tie, then write
        push_iss(CL_READ, 32'h40, 30'd8, '0);
        push_done(CL_READ, 1'b0, fill(32'hA5A5_0001));
        push_iss(CL_WRITE, 32'h80, 30'd4, fill(32'h1234_5678));
        push_done(CL_WRITE, 1'b0, '0);
        rd_addr = 32'h40;  rd_nelems = 30'd8; rd_req = 1'b1;
        wr_addr = 32'h80;  wr_nelems = 30'd4; wr_data = fill(32'h1234_5678); wr_req = 1'b1;
        req_cyc = cyc;
        wait_start("cont_rd", 1);
        check("cont_rd_start_lat", 64'(start_cyc), 64'(req_cyc + 1));
        tick(2);
        pulse_end(CL_READ, fill(32'hA5A5_0001));
        wait_done("cont_rd", 1);
        check("cont_rd_done_lat", 64'(done_cyc), 64'(end_cyc + 1));
        tick();
        rd_req = 1'b0;
        wait_start("cont_wr", 2);
        check("cont_rearb_lat", 64'(start_cyc), 64'(done_cyc + 2));
        pulse_end(CL_WRITE, '0);           // end sampled during ISSUE
        wait_done("cont_wr", 2);
        check("issue_end_lat", 64'(done_cyc), 64'(end_cyc + 1));
        tick();
        wr_req = 1'b0;
        tick(2);

        // single read of 15 elements, stray write-end ignored while waiting
        push_iss(CL_READ, 32'h0, 30'd15, '0);
        push_done(CL_READ, 1'b0, fill(32'hDEAD_BEEF));
        rd_addr = 32'h0; rd_nelems = 30'd15; rd_req = 1'b1;
        req_cyc = cyc;
        wait_start("rd", n_st);
        check("rd_start_lat", 64'(start_cyc), 64'(req_cyc + 1));
        tick(2);
        sdr_writeend = 1'b1;
        tick();
        sdr_writeend = 1'b0;
        tick(2);
        check("rd_ignores_wrend", 64'(done_cnt), 64'(n_dn - 1));
        check("rd_busy_wait", 64'(busy), 64'd1);
        check("rd_end_offset", 64'(cyc - start_cyc), 64'd5);
        pulse_end(CL_READ, fill(32'hDEAD_BEEF));
        wait_done("rd", n_dn);
        check("rd_done_lat", 64'(done_cyc), 64'(end_cyc + 1));
        tick();
        rd_req = 1'b0;
        tick(2);

        // last served is READ: a tie now goes to the write of 64 elements first
        push_iss(CL_WRITE, 32'h100, 30'd64, fill(32'hBEEF_D00D));
        push_done(CL_WRITE, 1'b0, '0);
        push_iss(CL_READ, 32'h200, 30'd32, '0);
        push_done(CL_READ, 1'b0, fill(32'h0BAD_F00D));
        wr_addr = 32'h100; wr_nelems = 30'd64; wr_data = fill(32'hBEEF_D00D); wr_req = 1'b1;
        rd_addr = 32'h200; rd_nelems = 30'd32; rd_req = 1'b1;
        wait_start("tie_wr", n_st - 1);
        wr_addr = 32'hFFFF_FFFF; wr_nelems = '0; wr_data = '1;
        for (int i = 0; i < 4; i++) begin
            @(negedge sdr_clk);
            check("wr_hold_addr", 64'(sdr_baseaddr), 64'h100);
            check("wr_hold_nelems", 64'(sdr_nelems), 64'd64);
            check("wr_hold_data", fold(sdr_writedata), fold(fill(32'hBEEF_D00D)));
        end
        #1;
        tick();
        pulse_end(CL_WRITE, '0);
        wait_done("tie_wr", n_dn - 1);
        tick();
        wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        wait_start("tie_rd", n_st);
        tick(3);
        pulse_end(CL_READ, fill(32'h0BAD_F00D));
        wait_done("tie_rd", n_dn);
        tick();
        rd_req = 1'b0;
        tick(2);

        // illegal counts: 0 and MAX+1 complete with err and no start pulse
        push_done(CL_READ, 1'b1, '0);
        rd_nelems = 30'd0; rd_req = 1'b1;
        req_cyc = cyc;
        wait_done("ill0", n_dn);
        check("ill0_lat", 64'(done_cyc), 64'(req_cyc + 1));
        tick();
        rd_req = 1'b0;
        tick(2);
        push_done(CL_WRITE, 1'b1, '0);
        wr_nelems = 30'd65; wr_req = 1'b1;
        req_cyc = cyc;
        wait_done("ill65", n_dn);
        check("ill65_lat", 64'(done_cyc), 64'(req_cyc + 1));
        tick();
        wr_req = 1'b0;
        tick(2);
        check("ill_no_start", 64'(start_cnt), 64'(n_st));

        // reset while waiting: no done, everything zero on the next cycle
        push_iss(CL_WRITE, 32'h300, 30'd4, fill(32'h5555_AAAA));
        wr_addr = 32'h300; wr_nelems = 30'd4; wr_data = fill(32'h5555_AAAA); wr_req = 1'b1;
        wait_start("rstw", n_st);
        tick(2);
        sdr_reset = 1'b1;
        wr_req = 1'b0;
        tick();
        check_all_zero("rst_wait");
        tick();
        sdr_reset = 1'b0;
        model_rd_data = '0;
        tick(3);
        check("rst_no_done", 64'(done_cnt), 64'(n_dn));

        // stray write-end in IDLE has no effect
        pulse_end(CL_WRITE, '0);
        @(negedge sdr_clk);
        check("stray_busy", 64'(busy), 64'd0);
        check("stray_no_done", 64'(done_cnt), 64'(n_dn));
        #1;
        tick();

        // clean write after reset
        push_iss(CL_WRITE, 32'h400, 30'd1, fill(32'hCAFE_F00D));
        push_done(CL_WRITE, 1'b0, '0);
        wr_addr = 32'h400; wr_nelems = 30'd1; wr_data = fill(32'hCAFE_F00D); wr_req = 1'b1;
        wait_start("post_rst", n_st);
        tick(3);
        pulse_end(CL_WRITE, '0);
        wait_done("post_rst", n_dn);
        tick();
        wr_req = 1'b0;
        tick(2);

`ifdef SDR_TIMEOUT_EN
        // watchdog: no end supplied, read aborts TMO cycles after its start
        push_iss(CL_READ, 32'h500, 30'd8, '0);
        push_done(CL_READ, 1'b1, '0);
        rd_addr = 32'h500; rd_nelems = 30'd8; rd_req = 1'b1;
        wait_start("tmo", n_st);
        wait_done("tmo", n_dn);
        check("tmo_lat", 64'(done_cyc - start_cyc), 64'(TMO));
        tick();
        rd_req = 1'b0;
        pulse_end(CL_READ, fill(32'hFFFF_0000));
        tick(2);
        check("tmo_late_end", 64'(done_cnt), 64'(n_dn));
        check("tmo_rd_data", fold(rd_data), fold(model_rd_data));
`endif

        tick(3);
        check("iss_q_empty", 64'(iss_q.size()), 64'd0);
        check("done_q_empty", 64'(done_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdr_xfer_arbiter.md
Name: sdr_xfer_arbiter

Overview:
- Sequences the shared SDRAM bulk-transfer port (`sdr_readstart`/`sdr_readend`, `sdr_writestart`/`sdr_writeend`, `sdr_baseaddr`, `sdr_nelems`, 2048-bit data).
- Shares that port between two clients: a read client (ray/scene fetch) and a write client (result writeback).
- Only one transfer is outstanding at a time.
- Sits between the raytracer core and the Computer_System SDR conduit, on the `sdr_clk` domain.

Parameters:
- DATA_W, 2048, width of the bulk data bus.
- ADDR_W, 32, width of `sdr_baseaddr`.
- NELEM_W, 30, width of `sdr_nelems`.
- MAX_NELEMS, 64, largest legal element count (DATA_W/32).
- TIMEOUT_CYC, 65536, watchdog limit in cycles; used only with SDR_TIMEOUT_EN.

Ports:
- sdr_clk  in  1  sole clock.
- sdr_reset  in  1  synchronous, active-high reset.
- rd_req  in  1  read client request; held high until rd_done.
- rd_addr  in  ADDR_W  read base address; stable while rd_req is high.
- rd_nelems  in  NELEM_W  read element count.
- rd_gnt  out  1  one-cycle pulse when the read transfer is issued.
- rd_done  out  1  one-cycle pulse when the read transfer completes.
- rd_data  out  DATA_W  captured `sdr_readdata`; valid from rd_done until the next read completes.
- wr_req  in  1  write client request.
- wr_addr  in  ADDR_W  write base address.
- wr_nelems  in  NELEM_W  write element count.
- wr_data  in  DATA_W  write payload.
- wr_gnt  out  1  one-cycle pulse when the write transfer is issued.
- wr_done  out  1  one-cycle pulse when the write transfer completes.
- err  out  1  qualifies rd_done/wr_done; 1 means the transfer was rejected or aborted.
- busy  out  1  high whenever the state is not IDLE.
- sdr_readstart  out  1  one-cycle start pulse to the SDR reader.
- sdr_writestart  out  1  one-cycle start pulse to the SDR writer.
- sdr_baseaddr  out  ADDR_W  latched transfer address.
- sdr_nelems  out  NELEM_W  latched transfer element count.
- sdr_writedata  out  DATA_W  latched write payload.
- sdr_readdata  in  DATA_W  read result from the SDR reader.
- sdr_readend  in  1  read-complete indication.
- sdr_writeend  in  1  write-complete indication.

Behaviour:
- Clocking and reset: one clock, `sdr_clk`. `sdr_reset` is synchronous and active-high.
- Reset values:
  - State = IDLE, last_served = WRITE (so a read wins the first tie).
  - All start/gnt/done/err/busy outputs = 0.
  - `sdr_baseaddr`, `sdr_nelems`, `sdr_writedata`, `rd_data` = 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If only one of rd_req/wr_req is high, that client is selected.
  - If both are high, the client not equal to last_served is selected.
  - On selection, latch addr/nelems (plus wr_data for a write) and go to ISSUE.
- Illegal count: if the selected nelems is 0 or greater than MAX_NELEMS, skip ISSUE and go straight to DONE with err=1. No start pulse is issued.
- ISSUE (exactly 1 cycle):
  - Assert the matching start signal and matching gnt, then go to WAIT.
  - `sdr_baseaddr`/`sdr_nelems` hold the latched values from ISSUE through DONE.
- WAIT:
  - Wait for the end signal matching the selected direction.
  - An end signal sampled during ISSUE or WAIT is accepted.
  - On a read end, capture `sdr_readdata` into `rd_data` on that edge, then go to DONE.
  - The non-matching end signal is ignored.
- DONE (1 cycle):
  - Pulse the matching done with err, update last_served, return to IDLE.
  - Outside ISSUE–DONE, `sdr_baseaddr`/`sdr_nelems` return to 0.
- Latency:
  - A request sampled in IDLE at cycle N gives start and gnt at N+1.
  - An end sampled at cycle M gives done at M+1.
  - The earliest re-arbitration is at M+2.
- Client rules:
  - A client must drop req in the cycle after its done; a req still high in IDLE is treated as a new request.
  - Client inputs may change after gnt.
- End signals seen in IDLE or DONE are ignored.
- Reset during ISSUE or WAIT: return to IDLE with no done pulse. Clients must re-request.

Optional Feature:
- Macro: SDR_TIMEOUT_EN.
- Defined:
  - A cycle counter clears on entry to ISSUE and counts in WAIT.
  - On reaching TIMEOUT_CYC-1 with no end seen, go to DONE with err=1.
  - `rd_data` is left unchanged.
  - A late end arriving afterwards is ignored.
- Undefined: no counter is built; WAIT holds indefinitely.

Decomposition:
- Package `sdr_arb_pkg` holds:
  - state enum {IDLE, ISSUE, WAIT, DONE};
  - client enum {CL_READ, CL_WRITE};
  - localparams for DATA_W/ADDR_W/NELEM_W defaults and MAX_NELEMS.
- One sub-module, `rr_arb2`: a two-input round-robin picker. Inputs are the two requests and last_served; outputs are the chosen client and a valid flag. It is purely combinational.

Test Plan:
- Read request: rd_req with addr 0x0, nelems 15 → `sdr_readstart` pulse with `sdr_nelems`=15; `sdr_readdata` = pattern 0xDEADBEEF per word with `sdr_readend` 5 cycles later → rd_done the next cycle and `rd_data` equal to the pattern.
- Contention: rd_req and wr_req asserted together from reset → read is issued first, write second. Then hold both high again → write is served before read.
- Write request: wr_req with addr 0x100, nelems 64, data 0xBEEFD00D… → `sdr_writedata`/`sdr_baseaddr` match and hold stable until `sdr_writeend`; wr_done with err=0.
- Illegal counts: nelems=0, then nelems=65 → done pulse with err=1 and no start pulse in either case.
- Reset and stray end: reset asserted in WAIT → no done, all outputs 0 next cycle. Stray `sdr_writeend` in IDLE → no effect.
- With SDR_TIMEOUT_EN and TIMEOUT_CYC=16: no end supplied → rd_done with err=1 exactly 16 cycles after the start pulse.
